// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch sequencer: one outstanding IMEM request,
// a single-entry decode buffer, redirect/kill handling and misaligned-target trap.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jb_taken,
    input  logic [31:0] jb_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        trap_misalign,
    output logic [31:0] trap_addr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        kill;
    logic        kill_nxt;
    logic        load_inst;
    logic        redirect;
    logic        misalign;

    // A misaligned target never redirects; it only raises the trap.
    assign redirect = jb_taken && (jb_target[1:0] == 2'b00);
    assign misalign = jb_taken && (jb_target[1:0] != 2'b00);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pc            <= RESET_PC;
            kill          <= 1'b0;
            inst_out      <= 32'h0;
            inst_pc       <= 32'h0;
            trap_misalign <= 1'b0;
            trap_addr     <= 32'h0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            kill          <= kill_nxt;
            trap_misalign <= misalign;
            if (load_inst) begin
                inst_out <= imem_rdata;
                inst_pc  <= pc;
            end
            if (misalign) begin
                trap_addr <= jb_target;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        kill_nxt  = kill;
        load_inst = 1'b0;
        unique case (state)
            ST_IDLE: begin
                state_nxt = ST_REQ;
                if (redirect) pc_nxt = jb_target;
            end
            ST_REQ: begin
                if (redirect) pc_nxt = jb_target;
                if (imem_ready) begin
                    state_nxt = ST_WAIT;
                    // Accepted request was for the old pc; its data must be dropped.
                    kill_nxt  = redirect;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    kill_nxt  = 1'b0;
                    state_nxt = ST_REQ;
                    if (redirect) begin
                        pc_nxt = jb_target;
                    end else if (!kill) begin
                        load_inst = 1'b1;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = ST_HOLD;
                    end
                end else if (redirect) begin
                    kill_nxt = 1'b1;
                    pc_nxt   = jb_target;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_nxt    = jb_target;
                    state_nxt = ST_REQ;
                end else if (!stall) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req   = (state == ST_REQ);
        imem_addr  = pc;
        inst_valid = (state == ST_HOLD);
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jb_taken = 1'b0;
    logic [31:0] jb_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        trap_misalign;
    logic [31:0] trap_addr;

    // Second instance for the wrap-around reset vector.
    logic        rst2 = 1'b1;
    logic        ready2 = 1'b0;
    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2 = 32'h0;
    logic        req2;
    logic [31:0] addr2;
    logic        ivalid2;
    logic [31:0] iout2;
    logic [31:0] ipc2;
    logic        trap2;
    logic [31:0] taddr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .jb_taken(jb_taken), .jb_target(jb_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_out(inst_out), .inst_pc(inst_pc), .trap_misalign(trap_misalign),
        .trap_addr(trap_addr)
    );

    pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst2), .stall(1'b0), .jb_taken(1'b0), .jb_target(32'h0),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2), .inst_valid(ivalid2),
        .inst_out(iout2), .inst_pc(ipc2), .trap_misalign(trap2), .trap_addr(taddr2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // IMEM contents: a fixed hash of the address, with one known word at 0x4.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0093;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    // Environment: IMEM responder holding at most one accepted request.
    bit          want_ready = 1'b0;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    // Reference model, expressed in terms of fetch transactions.
    bit          m_idle;
    bit          m_busy;
    bit          m_stale;
    bit          m_buf_valid;
    logic [31:0] m_buf_inst;
    logic [31:0] m_buf_pc;
    logic [31:0] m_pc;
    bit          m_trap;
    logic [31:0] m_trap_addr;

    function automatic bit m_req();
        return !m_idle && !m_busy && !m_buf_valid;
    endfunction

    task automatic model_update();
        bit redir;
        bit mis;
        bit accept;
        if (rst) begin
            m_idle = 1; m_busy = 0; m_stale = 0; m_buf_valid = 0;
            m_buf_inst = 32'h0; m_buf_pc = 32'h0; m_pc = 32'h0;
            m_trap = 0; m_trap_addr = 32'h0;
            return;
        end
        redir  = jb_taken && (jb_target[1:0] == 2'b00);
        mis    = jb_taken && (jb_target[1:0] != 2'b00);
        accept = m_req() && imem_ready;
        m_trap = mis;
        if (mis) m_trap_addr = jb_target;
        if (m_idle) begin
            m_idle = 0;
            if (redir) m_pc = jb_target;
        end else if (m_buf_valid) begin
            if (redir) begin
                m_buf_valid = 0;
                m_pc = jb_target;
            end else if (!stall) begin
                m_buf_valid = 0;
            end
        end else if (m_busy) begin
            if (imem_rvalid) begin
                m_busy = 0;
                if (redir) m_pc = jb_target;
                else if (!m_stale) begin
                    m_buf_valid = 1;
                    m_buf_inst = imem_rdata;
                    m_buf_pc = m_pc;
                    m_pc = m_pc + 32'd4;
                end
                m_stale = 0;
            end else if (redir) begin
                m_stale = 1;
                m_pc = jb_target;
            end
        end else begin
            if (accept) begin
                m_busy = 1;
                m_stale = redir;
            end
            if (redir) m_pc = jb_target;
        end
    endtask

    task automatic compare_model();
        check("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
        if (m_req()) check("imem_addr", imem_addr, m_pc);
        check("inst_valid", {31'h0, inst_valid}, {31'h0, m_buf_valid});
        check("inst_out", inst_out, m_buf_inst);
        check("inst_pc", inst_pc, m_buf_pc);
        check("trap_misalign", {31'h0, trap_misalign}, {31'h0, m_trap});
        check("trap_addr", trap_addr, m_trap_addr);
    endtask

    // One clock cycle: finish environment inputs, clock, update model, compare.
    task automatic step();
        bit          req_s;
        logic [31:0] addr_s;
        req_s  = imem_req;
        addr_s = imem_addr;
        if (pend && pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_ready = want_ready && !pend;
        @(posedge clk);
        if (imem_rvalid) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (req_s && imem_ready) begin
            pend      = 1'b1;
            pend_addr = addr_s;
            pend_cnt  = $urandom_range(lat_max, lat_min);
        end
        model_update();
        @(negedge clk);
        compare_model();
    endtask

    task automatic cycle2();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          saw_valid;
        logic [31:0] r;

        // Reset and zero-wait fetch sequence.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_req", {31'h0, imem_req}, 32'h0);
        check("reset_valid", {31'h0, inst_valid}, 32'h0);
        check("reset_inst", inst_out, 32'h0);
        check("reset_trap_addr", trap_addr, 32'h0);
        want_ready = 1'b1;
        step();
        check("seq_addr0", imem_addr, 32'h0);
        step();
        step();
        check("seq_valid0", {31'h0, inst_valid}, 32'h1);
        check("seq_pc0", inst_pc, 32'h0);
        step();
        check("seq_pulse0", {31'h0, inst_valid}, 32'h0);
        check("seq_addr1", imem_addr, 32'h4);
        step();
        stall = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'h0, inst_valid}, 32'h1);
            check("stall_inst", inst_out, 32'h0050_0093);
            check("stall_pc", inst_pc, 32'h4);
            check("stall_noreq", {31'h0, imem_req}, 32'h0);
            if (i < 4) step();
        end
        stall = 1'b0;
        step();
        check("seq_addr2", imem_addr, 32'h8);
        check("seq_req2", {31'h0, imem_req}, 32'h1);

        // Redirect while waiting: returning word must be dropped.
        lat_min = 3; lat_max = 3;
        step();
        jb_taken = 1'b1; jb_target = 32'h100;
        step();
        jb_taken = 1'b0;
        n = 0; saw_valid = 0;
        while (!imem_req && n < 10) begin
            step();
            if (inst_valid) saw_valid = 1;
            n++;
        end
        check("kill_no_valid", {31'h0, saw_valid}, 32'h0);
        check("kill_req_seen", {31'h0, imem_req}, 32'h1);
        check("kill_next_addr", imem_addr, 32'h100);

        // Redirect in HOLD overrides stall.
        lat_min = 0; lat_max = 0;
        step();
        step();
        check("hold_pc", inst_pc, 32'h100);
        stall = 1'b1; jb_taken = 1'b1; jb_target = 32'h200;
        step();
        stall = 1'b0; jb_taken = 1'b0;
        check("flush_valid", {31'h0, inst_valid}, 32'h0);
        check("flush_addr", imem_addr, 32'h200);

        // Misaligned target: trap only, fetch unaffected.
        want_ready = 1'b0;
        jb_taken = 1'b1; jb_target = 32'h102;
        step();
        jb_taken = 1'b0;
        check("mis_pulse", {31'h0, trap_misalign}, 32'h1);
        check("mis_addr", trap_addr, 32'h102);
        check("mis_fetch_addr", imem_addr, 32'h200);
        step();
        check("mis_pulse_end", {31'h0, trap_misalign}, 32'h0);
        check("mis_addr_held", trap_addr, 32'h102);

        // Randomized traffic against the model.
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            stall      = ($urandom_range(0, 2) == 0);
            want_ready = ($urandom_range(0, 2) != 0);
            jb_taken   = ($urandom_range(0, 7) == 0);
            r = $urandom;
            case ($urandom_range(0, 3))
                0: jb_target = {r[31:2], 2'b00};
                1: jb_target = 32'hFFFF_FFF0 + {28'h0, r[3:2], 2'b00};
                2: jb_target = {r[31:2], r[1:0] | 2'b01};
                default: jb_target = {24'h0, r[7:2], 2'b00};
            endcase
            step();
        end
        rst = 1'b0; jb_taken = 1'b0; stall = 1'b0;

        // Wrap-around reset vector and reset while a fetch is outstanding.
        rst2 = 1'b1;
        cycle2();
        rst2 = 1'b0;
        check("w_reset_req", {31'h0, req2}, 32'h0);
        cycle2();
        check("w_req", {31'h0, req2}, 32'h1);
        check("w_addr0", addr2, 32'hFFFF_FFFC);
        ready2 = 1'b1;
        cycle2();
        ready2 = 1'b0;
        check("w_wait_noreq", {31'h0, req2}, 32'h0);
        rvalid2 = 1'b1; rdata2 = 32'h0000_0013;
        cycle2();
        rvalid2 = 1'b0;
        check("w_valid", {31'h0, ivalid2}, 32'h1);
        check("w_pc", ipc2, 32'hFFFF_FFFC);
        check("w_inst", iout2, 32'h0000_0013);
        cycle2();
        check("w_addr_wrap", addr2, 32'h0);
        ready2 = 1'b1;
        cycle2();
        ready2 = 1'b0;
        rst2 = 1'b1;
        cycle2();
        rst2 = 1'b0;
        check("w_rst_valid", {31'h0, ivalid2}, 32'h0);
        check("w_rst_pc", ipc2, 32'h0);
        rvalid2 = 1'b1; rdata2 = 32'hDEAD_BEEF;
        cycle2();
        check("w_late_valid_idle", {31'h0, ivalid2}, 32'h0);
        check("w_late_req", {31'h0, req2}, 32'h1);
        check("w_late_addr", addr2, 32'hFFFF_FFFC);
        cycle2();
        rvalid2 = 1'b0;
        check("w_late_valid_req", {31'h0, ivalid2}, 32'h0);
        check("w_late_inst", iout2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
